switch_allocator_rr: RTL and testbench
======================================

// Module: switch_allocator_rr
// PURPOSE
//  Downstream stage of the output-port selection logic in each router.
//  Consumes the one-hot per-input output request and allocates every output port to at most one input.
//  Uses a round-robin arbiter per output and wormhole locking: a port stays held from the head flit until its tail flit transfers.
//  Pulses a per-input update strobe on each tail transfer; this strobe is the pheromone-update enable fed back to selection.
// PARAMETERS
//  N          5   number of router ports (0 = local, 1..N-1 = neighbours)
//  PTR_W      $clog2(N)  width of round-robin pointer / input index
// PORTS
//  clk            in   1          single clock; all state updates on rising edge
//  reset          in   1          synchronous, active-high reset
//  i_output_req   in   [0:N-1][0:N-1]  req[i][j]=1: input i's head flit wants output j (one-hot per i)
//  i_valid        in   [0:N-1]    input i presents a flit this cycle
//  i_tail         in   [0:N-1]    flit at input i is a tail (head==tail allowed)
//  i_en           in   [0:N-1]    output j can accept a flit this cycle (downstream not full)
//  o_grant        out  [0:N-1][0:N-1]  registered; grant[j][i]=1: output j locked to input i
//  o_input_sel    out  [0:N-1][PTR_W-1:0]  registered; index of input owning output j (0 when free)
//  o_busy         out  [0:N-1]    registered; output j locked
//  o_transfer     out  [0:N-1]    comb; input i's flit crosses the crossbar this cycle
//  o_update       out  [0:N-1]    registered 1-cycle pulse: input i's tail transferred last cycle
// BEHAVIOUR
//  Reset: o_grant, o_input_sel, o_busy, and o_update are all 0.
//  Reset: every round-robin pointer ptr[j] is set to 0.
//  Reset is honoured mid-packet: the lock is dropped at once with no tail required.
//  Per-output FSM, states IDLE and LOCKED.
//  IDLE, candidates: inputs i with i_valid[i] & req[i][j] & i not already owning an output & i!=j.
//   Requests with i==j (U-turn) are ignored.
//  IDLE, arbitration: winner is the first candidate searched from ptr[j] upward, mod N.
//   No candidate: stay IDLE.
//   Winner found: at next edge go LOCKED, grant[j][winner]=1, busy[j]=1.
//  Grant latency: request seen in cycle t -> o_grant high in cycle t+1.
//   No transfer happens in cycle t.
//  Multiple outputs in the same cycle: resolved in ascending j order.
//   An input granted by a lower j is excluded from higher j, so each input holds at most one output.
//  Non-one-hot request vector: only the lowest requested j is honoured.
//   The bench flags this as a protocol error.
//  LOCKED to input k: o_transfer[k] = i_valid[k] & i_en[j].
//   The lock is held even if k drops its request or valid.
//   No other input may use j while locked.
//  Release: transfer with i_tail[k]=1 -> next edge goes IDLE, grant row cleared.
//   Same edge: ptr[j] = (k+1) mod N (wrap N-1 -> 0).
//   Same edge: o_update[k]=1 for exactly one cycle.
//  After release, j re-arbitrates in the first IDLE cycle.
//   The next grant is visible 2 cycles after the tail transfer (one bubble by design).
//  A single-flit packet (head=tail) locks, transfers, and releases as above.
//   It always takes at least 2 cycles per output.
//  i_en low while locked: o_transfer=0 and the lock is held indefinitely (no timeout).
//  o_update[k] and a new grant to k on another output may coincide; they are independent.
//  Pointers advance only on release, never on grant.
// TESTING
//  Reset, then req[1][2]=1, valid[1]=1, en[2]=1 -> cycle+1: grant[2][1]=1, busy[2]=1, transfer[1]=1.
//   Then tail on input 1 -> next cycle busy[2]=0, update[1]=1 for one cycle.
//  Inputs 0,1,3 all request output 4 continuously with single-flit packets.
//   Required grants to 4 with ptr starting at 0: 0,1,3,0,1,3...
//   Each grant lasts exactly 2 cycles (lock + release bubble).
//  Input 2 locks output 1 with a 4-flit packet while en[1] toggles 1,0,1,0...
//   -> transfer[2] follows en[1]; tail lands on the 4th transfer; the lock is never lost.
//  Input 3 holds output 0 mid-packet; input 1 requests output 0.
//   -> no grant to 1 until cycle+2 after input 3's tail transfer.
//  reset asserted while outputs 1 and 3 are locked -> next cycle all grant/busy/update=0.
//   A pending request is granted to input 0 first (ptr=0).
//  req[2][2]=1 (U-turn) and req[4]=5'b00110 (non-one-hot).
//   -> no grant to 2; input 4 gets output 2 only; the bench error flag fires.

Source files
------------

// File: rtl/switch_allocator_rr.sv
// Per-output round-robin switch allocator with wormhole locking.
// Each output holds its winner from head to tail and pulses o_update when the tail crosses.
module switch_allocator_rr #(
  parameter int unsigned N     = 5,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [0:N-1][0:N-1]     i_output_req,
  input  logic [0:N-1]            i_valid,
  input  logic [0:N-1]            i_tail,
  input  logic [0:N-1]            i_en,
  output logic [0:N-1][0:N-1]     o_grant,
  output logic [0:N-1][PTR_W-1:0] o_input_sel,
  output logic [0:N-1]            o_busy,
  output logic [0:N-1]            o_transfer,
  output logic [0:N-1]            o_update
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                  state_q [N];
  state_e                  state_d [N];
  logic [0:N-1][0:N-1]     grant_q, grant_d;
  logic [0:N-1][PTR_W-1:0] sel_q, sel_d;
  logic [0:N-1][PTR_W-1:0] ptr_q, ptr_d;
  logic [0:N-1]            busy_q, busy_d;
  logic [0:N-1]            update_q, update_d;

  logic [0:N-1][0:N-1]     req_eff;
  logic                    lower_seen;
  logic [0:N-1]            owned;
  logic [0:N-1]            taken;
  logic                    found;
  logic [PTR_W-1:0]        win;
  logic [PTR_W-1:0]        owner;
  logic [PTR_W-1:0]        cand;
  logic [PTR_W:0]          idx;

  // Keep only the lowest requested output per input; U-turn requests never qualify.
  always_comb begin
    req_eff    = '0;
    lower_seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      lower_seen = 1'b0;
      for (int j = 0; j < N; j++) begin
        req_eff[i][j] = i_output_req[i][j] & ~lower_seen & (i != j);
        lower_seen    = lower_seen | i_output_req[i][j];
      end
    end
  end

  // Inputs that already hold an output are not eligible for another one.
  always_comb begin
    owned = '0;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        owned[i] = owned[i] | grant_q[j][i];
      end
    end
  end

  // Per-output next state; outputs are visited in ascending order so lower j wins an input first.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    busy_d     = busy_q;
    ptr_d      = ptr_q;
    update_d   = '0;
    o_transfer = '0;
    taken      = owned;
    found      = 1'b0;
    win        = '0;
    owner      = '0;
    cand       = '0;
    idx        = '0;
    for (int j = 0; j < N; j++) begin
      owner = sel_q[j];
      found = 1'b0;
      win   = '0;
      case (state_q[j])
        LOCKED: begin
          if (i_valid[owner] && i_en[j]) begin
            o_transfer[owner] = 1'b1;
            if (i_tail[owner]) begin
              state_d[j]      = IDLE;
              grant_d[j]      = '0;
              sel_d[j]        = '0;
              busy_d[j]       = 1'b0;
              ptr_d[j]        = (owner == PTR_W'(N - 1)) ? '0 : PTR_W'(owner + 1'b1);
              update_d[owner] = 1'b1;
            end
          end
        end
        default: begin
          for (int s = 0; s < N; s++) begin
            idx = {1'b0, ptr_q[j]} + (PTR_W + 1)'(s);
            if (idx >= (PTR_W + 1)'(N)) begin
              idx = idx - (PTR_W + 1)'(N);
            end
            cand = idx[PTR_W-1:0];
            if (!found && i_valid[cand] && req_eff[cand][j] && !taken[cand]) begin
              found = 1'b1;
              win   = cand;
            end
          end
          if (found) begin
            state_d[j]      = LOCKED;
            grant_d[j][win] = 1'b1;
            sel_d[j]        = win;
            busy_d[j]       = 1'b1;
            taken[win]      = 1'b1;
          end
        end
      endcase
    end
  end

  // Reset drops every lock immediately, mid-packet included.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < N; j++) begin
        state_q[j] <= IDLE;
      end
      grant_q  <= '0;
      sel_q    <= '0;
      ptr_q    <= '0;
      busy_q   <= '0;
      update_q <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        state_q[j] <= state_d[j];
      end
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      update_q <= update_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_input_sel = sel_q;
  assign o_busy      = busy_q;
  assign o_update    = update_q;

endmodule

// File: tb/tb_switch_allocator_rr.sv
// Bench for switch_allocator_rr: owner/pointer model checked every cycle plus directed literal checks.
module tb_switch_allocator_rr;

  localparam int unsigned N     = 5;
  localparam int unsigned PTR_W = 3;

  logic                    clk;
  logic                    reset;
  logic [0:N-1][0:N-1]     req;
  logic [0:N-1]            valid;
  logic [0:N-1]            tail;
  logic [0:N-1]            en;
  logic [0:N-1][0:N-1]     o_grant;
  logic [0:N-1][PTR_W-1:0] o_input_sel;
  logic [0:N-1]            o_busy;
  logic [0:N-1]            o_transfer;
  logic [0:N-1]            o_update;

  switch_allocator_rr #(.N(N), .PTR_W(PTR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_output_req (req),
    .i_valid      (valid),
    .i_tail       (tail),
    .i_en         (en),
    .o_grant      (o_grant),
    .o_input_sel  (o_input_sel),
    .o_busy       (o_busy),
    .o_transfer   (o_transfer),
    .o_update     (o_update)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int proto_err_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("%0t FAIL %s: got %0h, expected %0h", $time, name, act, exp);
  endtask

  // Model: which input owns each output (-1 = free), round-robin pointers, pending update pulses.
  int          m_owner [N];
  int          m_ptr   [N];
  logic [0:N-1] m_upd;
  bit          m_init = 1'b0;

  function automatic int first_req(input int i);
    for (int j = 0; j < N; j++) if (req[i][j]) return j;
    return -1;
  endfunction

  task automatic model_step();
    int          nown [N];
    bit          holds [N];
    logic [0:N-1] nupd;
    int          k;
    int          c;
    if (reset) begin
      for (int j = 0; j < N; j++) begin
        m_owner[j] = -1;
        m_ptr[j]   = 0;
      end
      m_upd  = '0;
      m_init = 1'b1;
      return;
    end
    if (!m_init) return;
    for (int i = 0; i < N; i++)
      if (valid[i] && $countones(req[i]) > 1) proto_err_cnt++;
    nupd = '0;
    for (int i = 0; i < N; i++) holds[i] = 1'b0;
    for (int j = 0; j < N; j++) if (m_owner[j] >= 0) holds[m_owner[j]] = 1'b1;
    for (int j = 0; j < N; j++) begin
      nown[j] = m_owner[j];
      if (m_owner[j] >= 0) begin
        k = m_owner[j];
        if (valid[k] && en[j] && tail[k]) begin
          nown[j]  = -1;
          m_ptr[j] = (k + 1) % N;
          nupd[k]  = 1'b1;
        end
      end else begin
        for (int s = 0; s < N; s++) begin
          c = (m_ptr[j] + s) % N;
          if (valid[c] && c != j && !holds[c] && first_req(c) == j) begin
            nown[j]  = c;
            holds[c] = 1'b1;
            break;
          end
        end
      end
    end
    m_owner = nown;
    m_upd   = nupd;
  endtask

  logic [0:N-1][0:N-1]     eg;
  logic [0:N-1][PTR_W-1:0] es;
  logic [0:N-1]            eb;
  logic [0:N-1]            et;

  // Compare every cycle just after the falling edge, then advance the model at the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m_init) begin
        eg = '0; es = '0; eb = '0; et = '0;
        for (int j = 0; j < N; j++) begin
          if (m_owner[j] >= 0) begin
            eg[j][m_owner[j]] = 1'b1;
            es[j]             = PTR_W'(m_owner[j]);
            eb[j]             = 1'b1;
            if (valid[m_owner[j]] && en[j]) et[m_owner[j]] = 1'b1;
          end
        end
        chk("cyc_grant",    64'(o_grant),     64'(eg));
        chk("cyc_sel",      64'(o_input_sel), 64'(es));
        chk("cyc_busy",     64'(o_busy),      64'(eb));
        chk("cyc_transfer", 64'(o_transfer),  64'(et));
        chk("cyc_update",   64'(o_update),    64'(m_upd));
      end
      @(posedge clk);
      model_step();
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic rst();
    cyc();
    reset = 1'b1;
    req   = '0;
    valid = '0;
    tail  = '0;
    en    = '1;
    cyc();
    reset = 1'b0;
  endtask

  int exp_seq [6] = '{0, 1, 3, 0, 1, 3};
  int ng;
  logic col2;

  initial begin
    reset = 1'b1;
    req   = '0;
    valid = '0;
    tail  = '0;
    en    = '1;

    // Reset values
    rst();
    #2;
    chk("rst_grant",  64'(o_grant),     64'd0);
    chk("rst_sel",    64'(o_input_sel), 64'd0);
    chk("rst_busy",   64'(o_busy),      64'd0);
    chk("rst_update", 64'(o_update),    64'd0);

    // Basic lock / transfer / release of output 2 by input 1
    cyc(); req[1][2] = 1'b1; valid[1] = 1'b1; #2;
    chk("t1_no_xfer_req_cycle", 64'(o_transfer[1]), 64'd0);
    cyc(); tail[1] = 1'b1; #2;
    chk("t1_grant21", 64'(o_grant[2][1]), 64'd1);
    chk("t1_busy2",   64'(o_busy[2]),     64'd1);
    chk("t1_xfer1",   64'(o_transfer[1]), 64'd1);
    cyc(); valid = '0; tail = '0; req = '0; #2;
    chk("t1_busy2_released", 64'(o_busy[2]),   64'd0);
    chk("t1_update1",        64'(o_update[1]), 64'd1);
    cyc(); #2;
    chk("t1_update1_once", 64'(o_update[1]), 64'd0);

    // Round robin on output 4 with single-flit packets from inputs 0,1,3
    rst();
    cyc();
    req[0][4] = 1'b1; req[1][4] = 1'b1; req[3][4] = 1'b1;
    valid[0] = 1'b1; valid[1] = 1'b1; valid[3] = 1'b1;
    tail[0]  = 1'b1; tail[1]  = 1'b1; tail[3]  = 1'b1;
    ng = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) cyc();
      #2;
      chk($sformatf("t2_busy4_c%0d", c), 64'(o_busy[4]), 64'(c % 2));
      if (o_busy[4]) begin
        if (ng < 6) chk($sformatf("t2_grant_%0d", ng), 64'(o_input_sel[4]), 64'(exp_seq[ng]));
        ng++;
      end
    end
    chk("t2_grant_count", 64'(ng), 64'd6);

    // 4-flit packet on output 1 with en[1] toggling
    rst();
    cyc(); req[2][1] = 1'b1; valid[2] = 1'b1; en[1] = 1'b1; #2;
    for (int c = 1; c < 8; c++) begin
      cyc();
      en[1]   = (c % 2) == 1;
      tail[2] = (c == 7);
      #2;
      chk($sformatf("t3_busy1_c%0d", c), 64'(o_busy[1]),     64'd1);
      chk($sformatf("t3_xfer2_c%0d", c), 64'(o_transfer[2]), 64'((c % 2) == 1));
    end
    cyc(); valid = '0; req = '0; tail = '0; en = '1; #2;
    chk("t3_released", 64'(o_busy[1]),   64'd0);
    chk("t3_update2",  64'(o_update[2]), 64'd1);

    // Input 1 waits on output 0 held by input 3 until two cycles after the tail
    rst();
    cyc(); req[3][0] = 1'b1; valid[3] = 1'b1; #2;
    cyc(); req[1][0] = 1'b1; valid[1] = 1'b1; #2;
    chk("t4_sel0_is3", 64'(o_input_sel[0]), 64'd3);
    for (int c = 2; c < 4; c++) begin
      cyc(); #2;
      chk($sformatf("t4_no_grant1_c%0d", c), 64'(o_grant[0][1]), 64'd0);
    end
    cyc(); tail[3] = 1'b1; #2;
    chk("t4_tail_xfer3", 64'(o_transfer[3]), 64'd1);
    cyc(); valid[3] = 1'b0; tail[3] = 1'b0; req[3] = '0; #2;
    chk("t4_bubble_busy0",  64'(o_busy[0]),     64'd0);
    chk("t4_bubble_grant1", 64'(o_grant[0][1]), 64'd0);
    cyc(); #2;
    chk("t4_grant01", 64'(o_grant[0][1]),   64'd1);
    chk("t4_sel0_is1", 64'(o_input_sel[0]), 64'd1);

    // Reset while outputs 1 and 3 are locked
    rst();
    cyc(); req[4][1] = 1'b1; valid[4] = 1'b1; req[2][3] = 1'b1; valid[2] = 1'b1; #2;
    cyc(); req[0][1] = 1'b1; valid[0] = 1'b1; #2;
    chk("t5_locked", 64'({o_busy[1], o_busy[3]}), 64'd3);
    chk("t5_sel1_is4", 64'(o_input_sel[1]), 64'd4);
    cyc(); reset = 1'b1; #2;
    cyc(); reset = 1'b0; #2;
    chk("t5_rst_grant",  64'(o_grant),  64'd0);
    chk("t5_rst_busy",   64'(o_busy),   64'd0);
    chk("t5_rst_update", 64'(o_update), 64'd0);
    cyc(); #2;
    chk("t5_grant10", 64'(o_grant[1][0]), 64'd1);
    chk("t5_sel1_is0", 64'(o_input_sel[1]), 64'd0);
    chk("t5_grant32", 64'(o_grant[3][2]), 64'd1);

    // U-turn and non-one-hot requests
    rst();
    #2;
    chk("t6_proto_clean", 64'(proto_err_cnt), 64'd0);
    cyc(); req[2][2] = 1'b1; valid[2] = 1'b1; req[4] = 5'b00110; valid[4] = 1'b1; #2;
    cyc(); #2;
    chk("t6_grant_row2", 64'(o_grant[2]), 64'(5'b00001));
    chk("t6_busy3",      64'(o_busy[3]),  64'd0);
    col2 = 1'b0;
    for (int j = 0; j < N; j++) col2 = col2 | o_grant[j][2];
    chk("t6_no_uturn_grant", 64'(col2), 64'd0);
    chk("t6_proto_flag", 64'(proto_err_cnt != 0), 64'd1);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
